enigma_seq: RTL



---
 rtl/enigma_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/enigma_seq.sv
// enigma_seq: sequencer that owns the enigma datapath and exposes it as a
// configuration stream and a character stream (valid/ready on both sides).
// Optional feature: define ENIGMA_SEQ_STATS_EN to add the char_cnt port, which
// counts characters sent through the rotors (wraps modulo 2^CNT_W).
module enigma_seq #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [14:0]       cfg_key,
    input  logic [1:0]        cfg_ra,
    input  logic [1:0]        cfg_rb,
    input  logic [1:0]        cfg_rc,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_char,
    output logic              busy,
    output logic [14:0]       enc_key,
    output logic [1:0]        enc_ra_cfg,
    output logic [1:0]        enc_rb_cfg,
    output logic [1:0]        enc_rc_cfg,
    output logic              enc_load_key,
    output logic              enc_new_char,
    output logic [4:0]        enc_char_in,
    input  logic [4:0]        enc_char_out
`ifdef ENIGMA_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]  char_cnt
`endif
);

    localparam int unsigned SET_W       = 4;
    localparam logic [4:0]  LAST_LETTER = 5'd25;
    localparam logic [1:0]  BAD_SEL     = 2'd3;

    typedef enum logic [2:0] {
        UNCFG,
        LOAD,
        READY,
        STEP,
        SETTLE,
        BYPASS,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               ready_st_q, ready_st_d;
    logic               busy_q, busy_d;
    logic               cfg_err_q, cfg_err_d;
    logic [14:0]        enc_key_q, enc_key_d;
    logic [1:0]         enc_ra_q, enc_ra_d;
    logic [1:0]         enc_rb_q, enc_rb_d;
    logic [1:0]         enc_rc_q, enc_rc_d;
    logic               enc_load_key_q, enc_load_key_d;
    logic               enc_new_char_q, enc_new_char_d;
    logic [4:0]         enc_char_in_q, enc_char_in_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         out_char_q, out_char_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
`ifdef ENIGMA_SEQ_STATS_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    logic               unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

    logic sel_bad_c, key_bad_c, cfg_hs_c, in_hs_c, out_hs_c;

    // Request legality and handshake decode; configuration wins over characters
    always_comb begin
        sel_bad_c = (cfg_ra == BAD_SEL) || (cfg_rb == BAD_SEL) || (cfg_rc == BAD_SEL) ||
                    (cfg_ra == cfg_rb)  || (cfg_ra == cfg_rc)  || (cfg_rb == cfg_rc);
        key_bad_c = (cfg_key[14:10] > LAST_LETTER) || (cfg_key[9:5] > LAST_LETTER) ||
                    (cfg_key[4:0] > LAST_LETTER);
        cfg_hs_c  = cfg_valid && cfg_ready_q;
        in_hs_c   = in_valid && in_ready;
        out_hs_c  = out_valid_q && out_ready;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d       = state_q;
        cfg_err_d     = cfg_err_q;
        enc_key_d     = enc_key_q;
        enc_ra_d      = enc_ra_q;
        enc_rb_d      = enc_rb_q;
        enc_rc_d      = enc_rc_q;
        enc_char_in_d = enc_char_in_q;
        out_valid_d   = out_valid_q;
        out_char_d    = out_char_q;
        settle_cnt_d  = settle_cnt_q;
`ifdef ENIGMA_SEQ_STATS_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            UNCFG, READY: begin
                if (cfg_hs_c) begin
                    if (sel_bad_c || key_bad_c) begin
                        cfg_err_d = 1'b1;
                        state_d   = UNCFG;
                    end else begin
                        cfg_err_d = 1'b0;
                        enc_key_d = cfg_key;
                        enc_ra_d  = cfg_ra;
                        enc_rb_d  = cfg_rb;
                        enc_rc_d  = cfg_rc;
`ifdef ENIGMA_SEQ_STATS_EN
                        cnt_d     = '0;
`endif
                        state_d   = LOAD;
                    end
                end else if (in_hs_c) begin
                    if (in_char <= LAST_LETTER) begin
                        enc_char_in_d = in_char;
                        state_d       = STEP;
                    end else begin
                        // Non-letter codes skip the rotors and are echoed straight out
                        out_char_d  = in_char;
                        out_valid_d = 1'b1;
                        state_d     = BYPASS;
                    end
                end
            end
            LOAD: state_d = READY;
            STEP: begin
                settle_cnt_d = '0;
`ifdef ENIGMA_SEQ_STATS_EN
                cnt_d        = cnt_q + CNT_W'(1);
`endif
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    out_char_d  = enc_char_out;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            BYPASS, HOLD: begin
                if (out_hs_c) begin
                    out_valid_d = 1'b0;
                    state_d     = READY;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = UNCFG;
        endcase

        cfg_ready_d    = (state_d == UNCFG) || (state_d == READY);
        ready_st_d     = (state_d == READY);
        busy_d         = !cfg_ready_d;
        enc_load_key_d = (state_d == LOAD);
        enc_new_char_d = (state_d == STEP);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= UNCFG;
            cfg_ready_q    <= 1'b0;
            ready_st_q     <= 1'b0;
            busy_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            enc_key_q      <= '0;
            enc_ra_q       <= '0;
            enc_rb_q       <= '0;
            enc_rc_q       <= '0;
            enc_load_key_q <= 1'b0;
            enc_new_char_q <= 1'b0;
            enc_char_in_q  <= '0;
            out_valid_q    <= 1'b0;
            out_char_q     <= '0;
            settle_cnt_q   <= '0;
`ifdef ENIGMA_SEQ_STATS_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cfg_ready_q    <= cfg_ready_d;
            ready_st_q     <= ready_st_d;
            busy_q         <= busy_d;
            cfg_err_q      <= cfg_err_d;
            enc_key_q      <= enc_key_d;
            enc_ra_q       <= enc_ra_d;
            enc_rb_q       <= enc_rb_d;
            enc_rc_q       <= enc_rc_d;
            enc_load_key_q <= enc_load_key_d;
            enc_new_char_q <= enc_new_char_d;
            enc_char_in_q  <= enc_char_in_d;
            out_valid_q    <= out_valid_d;
            out_char_q     <= out_char_d;
            settle_cnt_q   <= settle_cnt_d;
`ifdef ENIGMA_SEQ_STATS_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign in_ready     = ready_st_q && !cfg_valid;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;
    assign enc_key      = enc_key_q;
    assign enc_ra_cfg   = enc_ra_q;
    assign enc_rb_cfg   = enc_rb_q;
    assign enc_rc_cfg   = enc_rc_q;
    assign enc_load_key = enc_load_key_q;
    assign enc_new_char = enc_new_char_q;
    assign enc_char_in  = enc_char_in_q;
    assign out_valid    = out_valid_q;
    assign out_char     = out_char_q;
`ifdef ENIGMA_SEQ_STATS_EN
    assign char_cnt     = cnt_q;
`endif

endmodule
